// File: rtl/chaos_pkg.sv
// Shared definitions for the chaotic pixel cipher: sequence word widths,
// pixel type, controller states and mode encoding.
package chaos_pkg;

  localparam int int_bits   = 6;
  localparam int frac_bits  = 25;
  localparam int total_bits = 1 + int_bits + frac_bits;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } mode_t;

endpackage

// File: rtl/chaos_key_fifo.sv
// Key FIFO between the chaotic sequence intake and the pixel datapath.
// Power-of-two depth; flush empties it in one cycle.
module chaos_key_fifo
  import chaos_pkg::*;
#(
  parameter int depth = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  pixel_t din,
  output pixel_t dout,
  output logic   full,
  output logic   empty
);

  localparam int aw = $clog2(depth);

  pixel_t         mem [depth];
  logic [aw-1:0]  wptr;
  logic [aw-1:0]  rptr;
  logic [aw:0]    count;

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rptr];
  assign full  = (count == (aw + 1)'(depth));
  assign empty = (count == '0);

endmodule

// File: rtl/chaotic_pixel_cipher.sv
// Chaotic pixel cipher: turns Lorenz (x, y, z) triples into 8-bit keys and
// encrypts/decrypts one gray frame over valid/ready pixel streams.
// Build option CHAOS_DIFFUSION_EN enables chaining over the previous cipher
// byte (seeded with IV each frame); without it the result is pixel ^ key.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | taking keys and pixels for the current frame
// DONE  | last pixel handed off; frame_done pulse
module chaotic_pixel_cipher
  import chaos_pkg::*;
#(
  parameter int          integerBits  = int_bits,
  parameter int          fractionBits = frac_bits,
  parameter int          imgWidth     = 64,
  parameter int          imgHeight    = 64,
  parameter int          imgDeep      = 8,
  parameter int          keyFifoDepth = 4,
  parameter logic [7:0]  IV           = 8'hA5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                mode,
  output logic                                busy,
  output logic                                frame_done,
  input  logic [integerBits+fractionBits:0]   seq_x,
  input  logic [integerBits+fractionBits:0]   seq_y,
  input  logic [integerBits+fractionBits:0]   seq_z,
  input  logic                                seq_valid,
  output logic                                seq_ready,
  input  logic [imgDeep-1:0]                  pix_in,
  input  logic                                pix_in_valid,
  output logic                                pix_in_ready,
  output logic [imgDeep-1:0]                  pix_out,
  output logic                                pix_out_valid,
  input  logic                                pix_out_ready,
  output logic                                pix_out_last
);

  localparam int              n_pix    = imgWidth * imgHeight;
  localparam int              cw       = $clog2(n_pix + 1);
  localparam logic [cw-1:0]   n_cnt    = cw'(n_pix);
  localparam logic [cw-1:0]   last_cnt = cw'(n_pix - 1);

  state_t         state;
  state_t         state_nx;
  mode_t          mode_q;
  logic [cw-1:0]  key_cnt;
  logic [cw-1:0]  pix_cnt;
  pixel_t         key_in;
  pixel_t         key_out;
  pixel_t         result;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           flush;
  logic           out_free;

  assign key_in   = seq_x[fractionBits-1 -: 8] ^ seq_y[fractionBits-1 -: 8] ^ seq_z[fractionBits-1 -: 8];
  assign out_free = !pix_out_valid || pix_out_ready;
  assign push     = seq_valid && seq_ready;
  assign pop      = pix_in_valid && pix_in_ready;
  assign flush    = (state == IDLE) && start;

  chaos_key_fifo #(
    .depth (keyFifoDepth)
  ) u_key_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (key_in),
    .dout  (key_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: the frame ends when the last pixel leaves the output register.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (pix_out_valid && pix_out_ready && pix_out_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    busy         = (state != IDLE);
    frame_done   = (state == DONE);
    seq_ready    = (state == RUN) && !fifo_full && (key_cnt < n_cnt);
    pix_in_ready = (state == RUN) && !fifo_empty && (pix_cnt < n_cnt) && out_free;
  end

  // Mode latch and per-frame key/pixel counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= ENC;
      key_cnt <= '0;
      pix_cnt <= '0;
    end else if (flush) begin
      mode_q  <= mode_t'(mode);
      key_cnt <= '0;
      pix_cnt <= '0;
    end else begin
      if (push) key_cnt <= key_cnt + 1'b1;
      if (pop)  pix_cnt <= pix_cnt + 1'b1;
    end
  end

  // Output register: loads on accept, holds while stalled, drains on hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_out       <= '0;
      pix_out_valid <= 1'b0;
      pix_out_last  <= 1'b0;
    end else if (pop) begin
      pix_out       <= result;
      pix_out_valid <= 1'b1;
      pix_out_last  <= (pix_cnt == last_cnt);
    end else if (pix_out_valid && pix_out_ready) begin
      pix_out_valid <= 1'b0;
      pix_out_last  <= 1'b0;
    end
  end

`ifdef CHAOS_DIFFUSION_EN
  pixel_t chain;

  assign result = pix_in ^ key_out ^ chain;

  // Chain tracks the previous cipher byte: our result when encrypting, the input when decrypting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        chain <= IV;
    else if (flush) chain <= IV;
    else if (pop)   chain <= (mode_q == ENC) ? result : pix_in;
  end
`else
  assign result = pix_in ^ key_out;
`endif

endmodule

// File: doc/chaotic_pixel_cipher.md
Name: chaotic_pixel_cipher

Overview:
Consumer end of the Lorenz chaotic sequence stream. Samples offered (x, y, z) fixed-point triples and derives one 8-bit key per triple from the fractional bits. Encrypts or decrypts one gray image frame, imgWidth*imgHeight pixels, over valid/ready pixel streams. Sits between the chaotic sequence source and the image DMA/AXI-stream path.

Parameters:
integerBits, 6, integer bits of the sequence words (sign bit is extra)
fractionBits, 25, fractional bits of the sequence words
imgWidth, 64, pixels per line
imgHeight, 64, lines per frame
imgDeep, 8, pixel width; fixed at 8 for this revision
keyFifoDepth, 4, key FIFO entries; power of two, >= 2
IV, 8'hA5, chaining seed loaded at frame start

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame when idle
mode  in  1  0 = encrypt, 1 = decrypt; sampled on start
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse after the last pixel leaves
seq_x  in  1+integerBits+fractionBits  signed chaotic x
seq_y  in  1+integerBits+fractionBits  signed chaotic y
seq_z  in  1+integerBits+fractionBits  signed chaotic z
seq_valid  in  1  triple offered
seq_ready  out  1  triple taken when valid and ready
pix_in  in  8  plain or cipher pixel
pix_in_valid  in  1  input pixel offered
pix_in_ready  out  1  input pixel taken
pix_out  out  8  result pixel
pix_out_valid  out  1  result valid
pix_out_ready  in  1  downstream accepts
pix_out_last  out  1  marks final pixel of frame, qualified by valid

Behaviour:
- Reset values (async, and also on every reset assertion mid-frame): state IDLE. busy, frame_done, seq_ready, pix_in_ready, pix_out_valid and pix_out_last all 0. pix_out = 0. FIFO empty. Counters 0. chain = IV. Any in-flight frame is abandoned; no partial output is held.
- States:
  - IDLE -> RUN on start. The same cycle latches mode, clears key_cnt, pix_cnt and the FIFO, and sets chain = IV.
  - RUN -> DONE when the output register hands off the pixel with pix_out_last = 1.
  - DONE -> IDLE after one cycle; frame_done = 1 only in DONE.
  - start is ignored outside IDLE.
- Key derivation: key = seq_x[F-1:F-8] ^ seq_y[F-1:F-8] ^ seq_z[F-1:F-8], where F = fractionBits. Pure bit-select; no arithmetic.
- Key intake: seq_ready = RUN && FIFO not full && key_cnt < N, where N = imgWidth*imgHeight. Push on seq_valid && seq_ready; key_cnt increments on push. Exactly N keys are consumed per frame; surplus triples stay unaccepted.
- Output register empty condition: empty or (pix_out_valid && pix_out_ready).
- Pixel intake: pix_in_ready = RUN && FIFO not empty && pix_cnt < N && output register empty. On accept, pop one key and compute:
  - encrypt: r = p ^ k ^ chain, then chain <= r
  - decrypt: r = c ^ k ^ chain, then chain <= c (the input cipher byte)
- Latency: the pixel accepted in cycle t appears as pix_out_valid in t+1. Full throughput is one pixel per clock when keys and downstream allow it.
- Output hold: pix_out and pix_out_last stay stable while valid && !ready.
- pix_out_last = 1 for the pixel with pix_cnt == N-1 at accept.
- Simultaneous FIFO push and pop: both take effect, count unchanged; legal when full (pop frees the slot) or empty (pop not allowed when empty, since pix_in_ready requires non-empty).
- Counter width: clog2(N+1). Counters never wrap within a frame.

Optional Feature:
CHAOS_DIFFUSION_EN
- Defined: chaining as above (CBC-style diffusion over previous cipher byte).
- Undefined: r = pixel ^ key in both modes, the chain register is removed, IV is unused, and mode only latches without changing datapath.

Decomposition:
- Shared package chaos_pkg holds:
  - the fixed-point width constants (integerBits, fractionBits, totalBits)
  - the pixel type (8-bit)
  - the state enum {IDLE, RUN, DONE}
  - the mode encoding (ENC=0, DEC=1)
- One sub-module: chaos_key_fifo. Synchronous FIFO, depth keyFifoDepth, width 8, async active-high reset and a synchronous flush input.

Test Plan:
- Key derivation: seq fraction bytes x = 0x12, y = 0x34, z = 0x7C, pix_in 0x3C, encrypt, diffusion on -> key 0x5A, pix_out 0xC3 (0x3C^0x5A^0xA5).
- Round trip: encrypt a 64x64 ramp frame, then decrypt the captured output with the same key stream -> exact ramp. pix_out_last only on pixel 4095; one frame_done pulse; busy low afterwards.
- Backpressure: pix_out_ready toggles 1-0-0-1 -> pix_out held stable while stalled; no duplicate or dropped pixels; chain matches the golden model.
- Key starvation: seq_valid low 10 cycles mid-frame -> pix_in_ready low, FIFO empty, resumes with no skipped key. After 4096 keys, seq_ready stays 0 despite seq_valid = 1.
- Reset mid-frame: rst at pixel 100 -> all outputs 0 next cycle. A new start then reproduces the first 100 outputs identically from IV.
- Macro off: same stimulus as the first scenario -> pix_out 0x66 (0x3C^0x5A).
